// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, op width and ireg op-field position.
// Pure constants; no logic, no latency, no flow control.
// Imported by the execute-stage top and the ALU core.
package alu_pkg;

   localparam int ALU_OP_W = 5;
   localparam int OP_HI    = 11;
   localparam int OP_LO    = 7;

   typedef logic [ALU_OP_W-1:0] alu_op_t;

   localparam alu_op_t ALU_ADD   = 5'd0;
   localparam alu_op_t ALU_SUB   = 5'd1;
   localparam alu_op_t ALU_AND   = 5'd2;
   localparam alu_op_t ALU_OR    = 5'd3;
   localparam alu_op_t ALU_XOR   = 5'd4;
   localparam alu_op_t ALU_SLL   = 5'd5;
   localparam alu_op_t ALU_SRL   = 5'd6;
   localparam alu_op_t ALU_SRA   = 5'd7;
   localparam alu_op_t ALU_SLT   = 5'd8;
   localparam alu_op_t ALU_SLTU  = 5'd9;
   localparam alu_op_t ALU_EQ    = 5'd10;
   localparam alu_op_t ALU_NOT   = 5'd11;
   localparam alu_op_t ALU_PASS1 = 5'd12;
   localparam alu_op_t ALU_MUL   = 5'd13;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Execute-stage bus: decode-side inputs, stage enable, and ALU/stage results.
// No latency of its own; no backpressure (the stage accepts every cycle).
// master = upstream driver of the stage, slave = the execute stage itself.
interface alu_exec_stage_if #(
   parameter int STAGE_W = 3
);

   logic               stage_en;
   logic [31:0]        ireg;
   logic [31:0]        reg_value_0;
   logic [31:0]        reg_value_1;
   logic [STAGE_W-1:0] stage;
   logic [31:0]        alu_out_comb;
   logic [31:0]        alu_result;

   modport master (
      output stage_en, ireg, reg_value_0, reg_value_1,
      input  stage, alu_out_comb, alu_result
   );

   modport slave (
      input  stage_en, ireg, reg_value_0, reg_value_1,
      output stage, alu_out_comb, alu_result
   );

endinterface

// File: rtl/alu_core.sv
// Pure combinational 32-bit op-select ALU, wrap-around arithmetic, no flags.
// Zero latency; no flow control. Op 13 multiplies only when ALU_MUL_EN is defined.
module alu_core
   import alu_pkg::*;
(
   input  alu_op_t     alu_op,
   input  logic [31:0] alu_in0,
   input  logic [31:0] alu_in1,
   output logic [31:0] alu_out
);

   logic [4:0] shamt;

   assign shamt = alu_in1[4:0];

   always_comb begin
      alu_out = '0;
      case (alu_op)
         ALU_ADD:   alu_out = alu_in0 + alu_in1;
         ALU_SUB:   alu_out = alu_in0 - alu_in1;
         ALU_AND:   alu_out = alu_in0 & alu_in1;
         ALU_OR:    alu_out = alu_in0 | alu_in1;
         ALU_XOR:   alu_out = alu_in0 ^ alu_in1;
         ALU_SLL:   alu_out = alu_in0 << shamt;
         ALU_SRL:   alu_out = alu_in0 >> shamt;
         ALU_SRA:   alu_out = $unsigned($signed(alu_in0) >>> shamt);
         ALU_SLT:   alu_out = {31'd0, $signed(alu_in0) < $signed(alu_in1)};
         ALU_SLTU:  alu_out = {31'd0, alu_in0 < alu_in1};
         ALU_EQ:    alu_out = {31'd0, alu_in0 == alu_in1};
         ALU_NOT:   alu_out = ~alu_in0;
         ALU_PASS1: alu_out = alu_in1;
`ifdef ALU_MUL_EN
         // Low word of the product is identical for signed and unsigned operands.
         ALU_MUL:   alu_out = alu_in0 * alu_in1;
`else
         ALU_MUL:   alu_out = '0;
`endif
         default:   alu_out = '0;
      endcase
   end

endmodule

// File: rtl/stage_counter.sv
// Free-running pipeline stage counter wrapping 0..NUM_STAGES-1.
// One-cycle update on enable; holds when stage_en is low; rst has priority.
module stage_counter #(
   parameter int NUM_STAGES = 5,
   parameter int STAGE_W    = $clog2(NUM_STAGES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stage_en,
   output logic [STAGE_W-1:0] stage
);

   localparam logic [STAGE_W-1:0] LAST = STAGE_W'(NUM_STAGES - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         stage <= '0;
      end else if (stage_en) begin
         stage <= (stage == LAST) ? '0 : stage + STAGE_W'(1);
      end
   end

endmodule

// File: rtl/alu_exec_stage.sv
// TinyCPU execute stage: stage counter, op/operand decode, ALU and EXE result register.
// alu_result is one cycle behind alu_out_comb; no backpressure. Optional macro: ALU_MUL_EN.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int STAGE_W    = $clog2(NUM_STAGES)
) (
   input logic             clk,
   input logic             rst,
   alu_exec_stage_if.slave bus
);

   alu_op_t     alu_op;
   logic [31:0] alu_in0;
   logic [31:0] alu_in1;
   logic        unused_ireg_bits;

   assign alu_op  = bus.ireg[OP_HI:OP_LO];
   assign alu_in0 = bus.reg_value_0;
   assign alu_in1 = bus.reg_value_1;

   // Remaining instruction bits carry no meaning for this stage.
   assign unused_ireg_bits = ^{bus.ireg[31:OP_HI+1], bus.ireg[OP_LO-1:0]};

   stage_counter #(
      .NUM_STAGES (NUM_STAGES),
      .STAGE_W    (STAGE_W)
   ) u_stage_counter (
      .clk      (clk),
      .rst      (rst),
      .stage_en (bus.stage_en),
      .stage    (bus.stage)
   );

   alu_core u_alu_core (
      .alu_op  (alu_op),
      .alu_in0 (alu_in0),
      .alu_in1 (alu_in1),
      .alu_out (bus.alu_out_comb)
   );

   // NOP bubbles (ireg=0) are loaded like any other op; downstream ignores them.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.alu_result <= '0;
      end else begin
         bus.alu_result <= bus.alu_out_comb;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed plus randomized bench for alu_exec_stage against an arithmetic reference model.
module tb_alu_exec_stage;

   localparam int NS = 5;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_stage;
   logic [31:0] exp_result;
   logic [31:0] exp_comb;

   alu_exec_stage_if #(.STAGE_W(3)) bus ();

   alu_exec_stage #(.NUM_STAGES(NS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
      int          sh;
      logic [63:0] ext;
      logic [63:0] prod;
      sh = int'(b & 32'd31);
      case (op)
         0:  return a + b;
         1:  return a - b;
         2:  return a & b;
         3:  return a | b;
         4:  return a ^ b;
         5:  return a << sh;
         6:  return a >> sh;
         7: begin
            ext = {{32{a[31]}}, a} >> sh;
            return ext[31:0];
         end
         8:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         9:  return (a < b) ? 32'd1 : 32'd0;
         10: return (a == b) ? 32'd1 : 32'd0;
         11: return ~a;
         12: return b;
         13: begin
`ifdef ALU_MUL_EN
            prod = {32'd0, a} * {32'd0, b};
            return prod[31:0];
`else
            prod = 64'd0;
            return prod[31:0];
`endif
         end
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      r = $urandom;
      bus.ireg        = {r[31:12], op, r[6:0]};
      bus.reg_value_0 = a;
      bus.reg_value_1 = b;
   endtask

   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv);
      set_op(op, a, b);
      #1;
      check({tag, "_comb"}, bus.alu_out_comb, expv);
      tick();
      check(tag, bus.alu_result, expv);
   endtask

   initial begin
      logic [31:0] mul_exp;
      rst             = 1'b1;
      bus.stage_en    = 1'b0;
      bus.ireg        = 32'd0;
      bus.reg_value_0 = 32'd3;
      bus.reg_value_1 = 32'd4;
      tick();
      check("rst_stage", {29'd0, bus.stage}, 32'd0);
      check("rst_result", bus.alu_result, 32'd0);
      check("rst_comb_valid", bus.alu_out_comb, 32'd7);

      // Wrap sequence
      rst          = 1'b0;
      bus.stage_en = 1'b1;
      exp_stage    = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         exp_stage = (exp_stage + 1) % NS;
         check("wrap_stage", 32'(exp_stage), {29'd0, bus.stage});
      end
      while (exp_stage != 3) begin
         tick();
         exp_stage = (exp_stage + 1) % NS;
      end
      check("at3_stage", {29'd0, bus.stage}, 32'd3);

      // Hold
      bus.stage_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hold_stage", {29'd0, bus.stage}, 32'd3);
      end
      rst          = 1'b1;
      bus.stage_en = 1'b1;
      tick();
      check("rst_pri_stage", {29'd0, bus.stage}, 32'd0);
      check("rst_pri_result", bus.alu_result, 32'd0);
      rst          = 1'b0;
      bus.stage_en = 1'b0;

      // NOP computes ADD
      bus.ireg        = 32'd0;
      bus.reg_value_0 = 32'hFFFF_FFFF;
      bus.reg_value_1 = 32'd1;
      tick();
      check("nop_add_wrap", bus.alu_result, 32'd0);

      run_op("sub", 5'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
      run_op("sra", 5'd7, 32'h8000_0000, 32'h21, 32'hC000_0000);
      run_op("srl", 5'd6, 32'h8000_0000, 32'h21, 32'h4000_0000);
      run_op("sll0", 5'd5, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678);
      run_op("slt", 5'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
      run_op("sltu", 5'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
      run_op("eq", 5'd10, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd1);
      run_op("not", 5'd11, 32'h0F0F_0000, 32'd9, 32'hF0F0_FFFF);
      run_op("pass1", 5'd12, 32'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      run_op("op31", 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
`ifdef ALU_MUL_EN
      mul_exp = 32'd42;
`else
      mul_exp = 32'd0;
`endif
      run_op("mul", 5'd13, 32'd7, 32'd6, mul_exp);

      // Randomized: ops, operands, enable and one mid-run reset
      exp_stage  = int'(bus.stage == 3'd0 ? 0 : 0);
      rst        = 1'b1;
      tick();
      rst        = 1'b0;
      exp_stage  = 0;
      exp_result = 32'd0;
      for (int i = 0; i < 300; i++) begin
         logic [4:0]  op;
         logic [31:0] a, b;
         op = (i < 40) ? 5'd0 : 5'($urandom_range(0, 31));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         if ($urandom_range(0, 7) == 0) b = a;
         set_op(op, a, b);
         bus.stage_en = 1'($urandom_range(0, 1));
         rst          = (i == 150);
         #1;
         exp_comb = ref_alu(int'(op), a, b);
         check("rand_comb", bus.alu_out_comb, exp_comb);
         tick();
         if (rst) begin
            exp_stage  = 0;
            exp_result = 32'd0;
         end else begin
            if (bus.stage_en) exp_stage = (exp_stage + 1) % NS;
            exp_result = exp_comb;
         end
         check("rand_result", bus.alu_result, exp_result);
         check("rand_stage", {29'd0, bus.stage}, 32'(exp_stage));
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage datapath slice of the pipelined TinyCPU core.
- Contains a free-running pipeline stage counter, an ALU operand/op-select control block, a 32-bit combinational ALU, and the EXE pipeline result register.
- Fed by the end-of-decode instruction register and the registered register-file read data.
- Its registered result feeds the MEM-stage result mux.

Parameters:
- NUM_STAGES, 5, number of pipeline stages the stage counter cycles through; must be ≥2.
- STAGE_W, $clog2(NUM_STAGES), width of the stage output.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- stage_en  in  1  stage counter advance enable.
- ireg  in  32  end-of-decode instruction register value.
- reg_value_0  in  32  registered register-file read data 0.
- reg_value_1  in  32  registered register-file read data 1.
- stage  out  STAGE_W  current pipeline stage.
- alu_out_comb  out  32  combinational ALU output; this is the D input of the result register.
- alu_result  out  32  registered ALU result.

Behaviour:
- Reset: on a rising clk with rst=1, stage<=0 and alu_result<=0. rst has priority over stage_en.
- Stage counter:
  - When stage_en=1, stage<=(stage==NUM_STAGES-1)?0:stage+1. Wraps with no skipped or extra states.
  - When stage_en=0, stage holds.
- Control decode (combinational):
  - alu_op = ireg[11:7].
  - alu_in0 = reg_value_0; alu_in1 = reg_value_1.
  - All other ireg bits are ignored.
- ALU ops (5-bit codes, 32-bit result, wrap-around arithmetic, no flags):
  - 0 ADD: in0+in1.
  - 1 SUB: in0-in1.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL: in0<<in1[4:0].
  - 6 SRL: logical shift right by in1[4:0].
  - 7 SRA: arithmetic shift right by in1[4:0].
  - 8 SLT: signed in0<in1 → 1, else 0.
  - 9 SLTU: unsigned compare, same encoding.
  - 10 EQ: in0==in1 → 1, else 0.
  - 11 NOT: ~in0.
  - 12 PASS1: in1.
  - 13 MUL: see Optional Feature.
  - All other codes → 0.
- Shift amounts use only in1[4:0]; upper bits of in1 are ignored. A shift by 0 returns in0.
- ireg=0 is the NOP/bubble and computes ADD of the operands. Downstream logic must ignore the result of a NOP.
- Result register:
  - Loads alu_out_comb every non-reset cycle; there is no enable.
  - Latency is exactly one cycle from operand/ireg change to alu_result.
- Reset asserted mid-operation zeroes alu_result on that edge. The combinational output is unaffected.
- alu_out_comb has no internal state and is valid during reset.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: op 13 returns the low 32 bits of in0*in1 (unsigned product; the low word is the same for signed operands).
- Undefined: op 13 returns 0 like any unused code, and no multiplier is synthesized.

Decomposition:
- Shared package alu_pkg holds:
  - the 5-bit opcode localparams (ALU_ADD..ALU_MUL);
  - ALU_OP_W=5;
  - the ireg op-field bit positions (OP_HI=11, OP_LO=7).
- Natural sub-modules:
  - stage_counter (parameterized wrap counter);
  - alu_core (pure combinational op-select ALU).
- The top instantiates both, performs the operand/op extraction inline, and holds the result register.

Test Plan:
- Reset/wrap: rst=1 one cycle, then stage_en=1 for 12 cycles → stage sequence 0,1,2,3,4,0,1,...; alu_result=0 after reset.
- Counter hold: stage_en=0 at stage=3 for 4 cycles → stage stays 3; reassert with rst=1 and stage_en=1 together → stage=0.
- Arithmetic: ireg[11:7]=0 with 0xFFFFFFFF and 1 → alu_result=0 one cycle later; op 1 with 0 and 1 → 0xFFFFFFFF.
- Shifts/compare:
  - SRA 0x80000000 by 0x21 → 0xC0000000 (amount 1).
  - SRL same operands → 0x40000000.
  - SLT 0xFFFFFFFF vs 1 → 1.
  - SLTU same operands → 0.
- Unused op and MUL:
  - op 31 → 0.
  - op 13 with 7,6 → 42 when ALU_MUL_EN is defined, 0 otherwise.
- Latency: change operands every cycle with ADD → alu_result equals the previous cycle's alu_out_comb on every edge.
